// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell reused over WIDTH cycles with a registered carry.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             c_out,
    output logic             ovf
`else
    output logic             c_out
`endif
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] part_sr_q, part_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             done_q, done_d;
    logic             fa_s, fa_co;

    // Single full-adder cell fed from the operand LSBs and the registered carry.
    assign fa_s  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_co = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        part_sr_d = part_sr_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        c_out_d   = c_out_q;
        done_d    = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d     = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sr_d    = a;
                    b_sr_d    = b;
                    carry_d   = c_in;
                    cnt_d     = '0;
                    part_sr_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                part_sr_d = {fa_s, part_sr_q[WIDTH-1:1]};
                a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d   = fa_co;
                if (cnt_q == CntLast) begin
                    // Final bit: publish the whole result at once, never partial values.
                    sum_d   = {fa_s, part_sr_q[WIDTH-1:1]};
                    c_out_d = fa_co;
                    done_d  = 1'b1;
                    state_d = StIdle;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB.
                    ovf_d   = fa_co ^ carry_q;
`endif
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            part_sr_q <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            c_out_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            part_sr_q <= part_sr_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            c_out_q   <= c_out_d;
            done_q    <= done_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy  = (state_q == StShift);
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule
